instruction_decode_stage: RTL
=============================

// Module: instruction_decode_stage
// PURPOSE
//  Stage 2 of the MIPS-Lite pipeline, directly downstream of instruction fetch. Holds the IF/ID latch
//  (instruction, pcPlus4) and reads the 32x32 register file (write port driven by writeback).
//  Decodes control, sign-extends the immediate, detects load-use hazards and HALT, and registers
//  the result into the ID/EX latch. Drives stall back to fetch to hold the PC.
// PARAMETERS
//  ADDRESSWIDTH  32  PC / pcPlus4 width (from mips_pkg)
//  DATAWIDTH     32  register and immediate-extended width (from mips_pkg)
//  NUMREGS       32  architectural registers; R0 reads 0, writes ignored
// PORTS
//  clk          in   1     single clock, rising edge
//  reset        in   1     asynchronous, active-high
//  instruction  in   32    Instruct from fetch
//  pcPlus4      in   32    from fetch
//  branchTaken  in   1     from EX; flush IF/ID and ID/EX
//  wbEnable     in   1     register-file write enable
//  wbReg        in   5     register-file write index
//  wbData       in   32    register-file write data
//  stall        out  1     fetch holds PC when 1 (combinational)
//  idexValid    out  1     ID/EX holds a real instruction
//  idexOpcode   out  6     Opcode enum
//  idexRsData   out  32    rs operand
//  idexRtData   out  32    rt operand
//  idexImm      out  32    sign-extended imm[15:0]
//  idexDest     out  5     destination register
//  idexRegWrite out  1     instruction writes a register
//  idexMemRead  out  1     LDW
//  idexMemWrite out  1     STW
//  idexPcPlus4  out  32    pcPlus4 of the instruction
//  halted       out  1     HALT has been decoded; pipeline front end frozen
// BEHAVIOUR
//  - Reset (async): all IF/ID and ID/EX fields 0, ifidValid=0, idexValid=0, register file all 0, FSM=RUN, halted=0.
//  - IF/ID: each edge captures instruction/pcPlus4, valid=1, unless stall=1 (hold).
//  - Register file: written on rising edge if wbEnable && wbReg!=0.
//  - Register file read bypass: same-cycle read of wbReg returns wbData.
//  - Opcodes (6b):
//      ADD=0 ADDI=1 SUB=2 SUBI=3 MUL=4 MULI=5 OR=6 ORI=7 AND=8 ANDI=9 XOR=10 XORI=11
//      LDW=12 STW=13 BZ=14 BEQ=15 JR=16 HALT=17.
//    Odd opcodes 1..11 are I-type.
//  - Decode: R-type dest=rd, I-type/LDW dest=rt.
//    regWrite=1 for opcodes 0..12. memRead=LDW. memWrite=STW.
//    Unknown opcode decodes as NOP (regWrite/mem=0).
//  - Immediate: always sign-extended, incl. logical ops.
//  - Latency: 1 cycle IF/ID->ID/EX. Results visible on idex* the edge after IF/ID capture.
//  - Load-use hazard:
//      stall = ifidValid && idexValid && idexMemRead && idexDest!=0
//              && (idexDest==rs || (usesRt && idexDest==rt)).
//      usesRt for R-type, STW, BEQ. Every opcode except HALT uses rs.
//    On stall: IF/ID holds, ID/EX loads bubble (idexValid=0, all control 0). Exactly 1 bubble per load-use.
//  - branchTaken (priority over stall): next edge IF/ID valid=0 and ID/EX bubble. stall forced 0.
//  - FSM RUN->HALTED when a valid HALT is in IF/ID and branchTaken=0. HALT itself passes to ID/EX as valid.
//    In HALTED: stall=1, ID/EX bubbles every cycle, halted=1. Only reset leaves HALTED.
//  - Priority: reset > branchTaken > HALTED > load-use stall > normal.
// STRUCTURE
//  - mips_pkg additions: Opcode enum, Instruct struct (opcode/rs/rt/rd/imm), IdEx struct, ADDRESSWIDTH/DATAWIDTH.
//  - One sub-module: register_file (2 read, 1 write, R0=0, write bypass).
//  - Fetch gains pcWrite=!stall on its programCounter.
// TESTING
//  - Reset asserted mid-run with valid latches -> all idex*=0, halted=0 the same cycle; R5 reads 0 afterwards.
//  - wb R3=0x0000_00AA; same cycle ADD R4,R3,R0 in IF/ID -> idexRsData=0xAA next edge (bypass).
//  - ADDI R1,R2,imm=0xFFFE -> idexImm=0xFFFF_FFFE, idexDest=1, idexRegWrite=1.
//  - LDW R7,0(R2) then ADD R8,R7,R1 -> stall=1 one cycle, one idexValid=0 bubble, ADD issues next cycle.
//  - LDW R0 followed by use of R0 -> no stall.
//  - Load-use stall with branchTaken=1 same cycle -> stall=0, both latches bubble next edge.
//  - HALT valid in IF/ID -> next edge idexOpcode=17, idexValid=1, halted=1.
//    Thereafter stall=1 and idexValid=0 until reset.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and helpers for the MIPS-Lite pipeline.
//   Opcode   - 6-bit opcode enum
//   Instruct - 32-bit instruction word: opcode[31:26] rs[25:21] rt[20:16] imm[15:0].
//              For R-type instructions rd lives in imm[15:11] (see instr_rd).
//   IdEx     - decoded control carried in the ID/EX latch
package mips_pkg;

  localparam int ADDRESSWIDTH = 32;
  localparam int DATAWIDTH    = 32;
  localparam int NUMREGS      = 32;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,  OP_ADDI = 6'd1,  OP_SUB  = 6'd2,  OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,  OP_MULI = 6'd5,  OP_OR   = 6'd6,  OP_ORI  = 6'd7,
    OP_AND  = 6'd8,  OP_ANDI = 6'd9,  OP_XOR  = 6'd10, OP_XORI = 6'd11,
    OP_LDW  = 6'd12, OP_STW  = 6'd13, OP_BZ   = 6'd14, OP_BEQ  = 6'd15,
    OP_JR   = 6'd16, OP_HALT = 6'd17
  } Opcode;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } Instruct;

  // Opcode is kept as raw bits so unknown encodings still pass through.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] dest;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
  } IdEx;

  function automatic logic [4:0] instr_rd(input Instruct i);
    return i.imm[15:11];
  endfunction

  // ALU ops 0..11: even = register form, odd = immediate form
  function automatic logic is_rtype(input logic [5:0] op);
    return (op <= 6'd10) && !op[0];
  endfunction

  function automatic logic is_itype(input logic [5:0] op);
    return (op <= 6'd11) && op[0];
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return op != OP_HALT;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return is_rtype(op) || (op == OP_STW) || (op == OP_BEQ);
  endfunction

  function automatic IdEx decode(input Instruct i);
    IdEx d;
    d        = '0;
    d.opcode = i.opcode;
    if (is_rtype(i.opcode)) begin
      d.dest     = instr_rd(i);
      d.regWrite = 1'b1;
    end else if (is_itype(i.opcode) || i.opcode == OP_LDW) begin
      d.dest     = i.rt;
      d.regWrite = 1'b1;
    end
    d.memRead  = (i.opcode == OP_LDW);
    d.memWrite = (i.opcode == OP_STW);
    return d;
  endfunction

endpackage

// File: rtl/register_file.sv
// register_file: NUMREGS x DATAWIDTH, two async read ports, one write port.
//   clk/reset        rising edge, async active-high clear
//   raddr1/rdata1    read port 1 (rs)
//   raddr2/rdata2    read port 2 (rt)
//   wen/waddr/wdata  write port; writes to R0 are dropped
// A read of the register being written this cycle returns wdata, so the
// writeback stage never needs an extra forwarding path into decode.
module register_file #(
  parameter int DATAWIDTH = 32,
  parameter int NUMREGS   = 32,
  parameter int REGW      = $clog2(NUMREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REGW-1:0]      raddr1,
  input  logic [REGW-1:0]      raddr2,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic [DATAWIDTH-1:0] rdata2,
  input  logic                 wen,
  input  logic [REGW-1:0]      waddr,
  input  logic [DATAWIDTH-1:0] wdata
);

  logic [NUMREGS-1:0][DATAWIDTH-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)                  rdata1 = '0;
    else if (wen && raddr1 == waddr)   rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)                  rdata2 = '0;
    else if (wen && raddr2 == waddr)   rdata2 = wdata;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: pipeline stage 2 (IF/ID latch -> decode -> ID/EX latch).
//   clk, reset            rising-edge clock, async active-high reset
//   instruction, pcPlus4  from fetch, captured into IF/ID unless stalled
//   branchTaken           from EX; flushes IF/ID and bubbles ID/EX
//   wbEnable/wbReg/wbData register-file write port (from writeback)
//   stall                 combinational; fetch holds its PC while high
//   idex*                 ID/EX latch contents (1-cycle latency after IF/ID)
//   halted                HALT decoded; front end frozen until reset
module instruction_decode_stage #(
  parameter int ADDRESSWIDTH = mips_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = mips_pkg::DATAWIDTH,
  parameter int NUMREGS      = mips_pkg::NUMREGS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instruction,
  input  logic [ADDRESSWIDTH-1:0] pcPlus4,
  input  logic                    branchTaken,
  input  logic                    wbEnable,
  input  logic [4:0]              wbReg,
  input  logic [DATAWIDTH-1:0]    wbData,
  output logic                    stall,
  output logic                    idexValid,
  output logic [5:0]              idexOpcode,
  output logic [DATAWIDTH-1:0]    idexRsData,
  output logic [DATAWIDTH-1:0]    idexRtData,
  output logic [DATAWIDTH-1:0]    idexImm,
  output logic [4:0]              idexDest,
  output logic                    idexRegWrite,
  output logic                    idexMemRead,
  output logic                    idexMemWrite,
  output logic [ADDRESSWIDTH-1:0] idexPcPlus4,
  output logic                    halted
);
  import mips_pkg::*;

  typedef enum logic {RUN, HALTED} state_t;

  state_t                  state, stateNext;
  Instruct                 ifidInstr;
  logic [ADDRESSWIDTH-1:0] ifidPc;
  logic [1:0]              vld_pipe;   // [0] IF/ID valid, [1] ID/EX valid
  IdEx                     idexCtl, dec;
  logic [DATAWIDTH-1:0]    rsData, rtData;
  logic                    loadUse, bubble;

  register_file #(.DATAWIDTH(DATAWIDTH), .NUMREGS(NUMREGS), .REGW(5)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (ifidInstr.rs),
    .raddr2 (ifidInstr.rt),
    .rdata1 (rsData),
    .rdata2 (rtData),
    .wen    (wbEnable),
    .waddr  (wbReg),
    .wdata  (wbData)
  );

  assign dec = decode(ifidInstr);

  // Load in EX whose destination is read by the instruction in ID
  assign loadUse = vld_pipe[0] && vld_pipe[1] && idexCtl.memRead && idexCtl.dest != 5'd0
                && ((uses_rs(ifidInstr.opcode) && idexCtl.dest == ifidInstr.rs)
                 || (uses_rt(ifidInstr.opcode) && idexCtl.dest == ifidInstr.rt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  // branchTaken outranks everything: the instructions in ID are on the wrong path
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    if (branchTaken) begin
      stall = 1'b0;
    end else if (state == HALTED) begin
      stall = 1'b1;
    end else begin
      stall = loadUse;
      if (vld_pipe[0] && ifidInstr.opcode == OP_HALT) stateNext = HALTED;
    end
  end

  assign bubble = branchTaken || stall || !vld_pipe[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifidInstr   <= '0;
      ifidPc      <= '0;
      vld_pipe    <= '0;
      idexCtl     <= '0;
      idexRsData  <= '0;
      idexRtData  <= '0;
      idexImm     <= '0;
      idexPcPlus4 <= '0;
    end else begin
      if (branchTaken) begin
        ifidInstr   <= '0;
        ifidPc      <= '0;
        vld_pipe[0] <= 1'b0;
      end else if (!stall) begin
        ifidInstr   <= Instruct'(instruction);
        ifidPc      <= pcPlus4;
        vld_pipe[0] <= 1'b1;
      end

      if (bubble) begin
        vld_pipe[1] <= 1'b0;
        idexCtl     <= '0;
        idexRsData  <= '0;
        idexRtData  <= '0;
        idexImm     <= '0;
        idexPcPlus4 <= '0;
      end else begin
        vld_pipe[1] <= 1'b1;
        idexCtl     <= dec;
        idexRsData  <= rsData;
        idexRtData  <= rtData;
        // sign-extended even for logical ops
        idexImm     <= {{(DATAWIDTH-16){ifidInstr.imm[15]}}, ifidInstr.imm};
        idexPcPlus4 <= ifidPc;
      end
    end
  end

  assign idexValid    = vld_pipe[1];
  assign idexOpcode   = idexCtl.opcode;
  assign idexDest     = idexCtl.dest;
  assign idexRegWrite = idexCtl.regWrite;
  assign idexMemRead  = idexCtl.memRead;
  assign idexMemWrite = idexCtl.memWrite;
  assign halted       = (state == HALTED);

endmodule
